// File: rtl/sram_pkg.sv
// Shared constants and helpers for the banked 1R1W SRAM.
package sram_pkg;

   localparam int SRAM_NB_DATA = 8192;
   localparam int SRAM_L_DATA  = 16;
   localparam int SRAM_NB_BANK = 4;
   localparam int SRAM_CNT_W   = 32;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction

endpackage

// File: rtl/sram_bank_1r1w.sv
// One SRAM bank: active-low enables, 1-cycle registered read, Q holds while idle.
// Behavioural stand-in for the foundry macro; contents are never reset.
module sram_bank_1r1w
   import sram_pkg::*;
#(
   parameter  int DEPTH  = SRAM_NB_DATA / SRAM_NB_BANK,
   parameter  int L_DATA = SRAM_L_DATA,
   localparam int L_A    = clog2(DEPTH)
)(
   input  logic              clk,
   input  logic              i_wen_n,
   input  logic [L_A-1:0]    i_waddr,
   input  logic [L_DATA-1:0] i_wdata,
   input  logic              i_ren_n,
   input  logic [L_A-1:0]    i_raddr,
   output logic [L_DATA-1:0] o_q
);

   logic [L_DATA-1:0] r_mem [DEPTH];
   logic [L_DATA-1:0] r_q;

   // Same-address read/write returns old data here; the parent bypasses it.
   always_ff @(posedge clk) begin
      if (!i_wen_n) r_mem[i_waddr] <= i_wdata;
      if (!i_ren_n) r_q <= r_mem[i_raddr];
   end

   assign o_q = r_q;

endmodule

// File: rtl/sram_banked_1r1w.sv
// Banked 1R1W SRAM with write-first bypass, held read data and saturating access counters.
// Define SRAM_BANKED_OUT_REG_EN to add an output register after the bank mux (read latency 2).
module sram_banked_1r1w
   import sram_pkg::*;
#(
   parameter  int NB_DATA = SRAM_NB_DATA,
   parameter  int L_DATA  = SRAM_L_DATA,
   parameter  int NB_BANK = SRAM_NB_BANK,
   parameter  int CNT_W   = SRAM_CNT_W,
   localparam int L_ADDR  = clog2(NB_DATA),
   localparam int L_BANK  = clog2(NB_BANK),
   localparam int L_BADDR = L_ADDR - L_BANK
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              wEn,
   input  logic [L_ADDR-1:0] wAddr,
   input  logic [L_DATA-1:0] wData,
   input  logic              rEn,
   input  logic [L_ADDR-1:0] rAddr,
   output logic [L_DATA-1:0] rData,
   output logic              rValid,
   input  logic              cntClr,
   output logic [CNT_W-1:0]  rdCnt,
   output logic [CNT_W-1:0]  wrCnt
);

   logic                            w_rd_acc, w_wr_acc;
   logic [L_BANK-1:0]               w_wbank, w_rbank;
   logic [NB_BANK-1:0]              w_wen_n, w_ren_n;
   logic [NB_BANK-1:0][L_DATA-1:0]  w_q;
   logic [L_DATA-1:0]               w_mux, w_rdata;

   logic [L_BANK-1:0]               r_rsel;
   logic                            r_byp, r_rd_seen;
   logic [L_DATA-1:0]               r_byp_data;
   logic [CNT_W-1:0]                r_rdcnt, r_wrcnt;

   assign w_rd_acc = ~rEn;
   assign w_wr_acc = ~wEn;
   assign w_wbank  = wAddr[L_ADDR-1 -: L_BANK];
   assign w_rbank  = rAddr[L_ADDR-1 -: L_BANK];

   for (genvar b = 0; b < NB_BANK; b++) begin : g_bank
      assign w_wen_n[b] = ~(w_wr_acc && (w_wbank == L_BANK'(b)));
      assign w_ren_n[b] = ~(w_rd_acc && (w_rbank == L_BANK'(b)));

      sram_bank_1r1w #(
         .DEPTH  (NB_DATA / NB_BANK),
         .L_DATA (L_DATA)
      ) u_bank (
         .clk     (clk),
         .i_wen_n (w_wen_n[b]),
         .i_waddr (wAddr[L_BADDR-1:0]),
         .i_wdata (wData),
         .i_ren_n (w_ren_n[b]),
         .i_raddr (rAddr[L_BADDR-1:0]),
         .o_q     (w_q[b])
      );
   end

   // Select and bypass only move on an accepted read, so the mux output holds otherwise.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rsel     <= '0;
         r_byp      <= 1'b0;
         r_byp_data <= '0;
         r_rd_seen  <= 1'b0;
      end else if (w_rd_acc) begin
         r_rsel     <= w_rbank;
         r_byp      <= w_wr_acc && (wAddr == rAddr);
         r_byp_data <= wData;
         r_rd_seen  <= 1'b1;
      end
   end

   // rData reads as zero from reset until the first read lands.
   assign w_mux   = r_byp ? r_byp_data : w_q[r_rsel];
   assign w_rdata = r_rd_seen ? w_mux : '0;

`ifdef SRAM_BANKED_OUT_REG_EN
   logic [1:0]        r_vld_pipe;
   logic [L_DATA-1:0] r_rdata_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_vld_pipe <= '0;
         r_rdata_q  <= '0;
      end else begin
         r_vld_pipe <= {r_vld_pipe[0], w_rd_acc};
         r_rdata_q  <= w_rdata;
      end
   end

   assign rValid = r_vld_pipe[1];
   assign rData  = r_rdata_q;
`else
   logic r_vld;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_vld <= 1'b0;
      else     r_vld <= w_rd_acc;
   end

   assign rValid = r_vld;
   assign rData  = w_rdata;
`endif

   // Clear beats a same-cycle increment; counts stick at all-ones.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rdcnt <= '0;
         r_wrcnt <= '0;
      end else if (cntClr) begin
         r_rdcnt <= '0;
         r_wrcnt <= '0;
      end else begin
         if (w_rd_acc && !(&r_rdcnt)) r_rdcnt <= r_rdcnt + 1'b1;
         if (w_wr_acc && !(&r_wrcnt)) r_wrcnt <= r_wrcnt + 1'b1;
      end
   end

   assign rdCnt = r_rdcnt;
   assign wrCnt = r_wrcnt;

endmodule

// File: tb/tb_sram_banked_1r1w.sv
// Self-checking bench for sram_banked_1r1w: fill/readback, directed table, random vs. model, reset, counters.
module tb_sram_banked_1r1w;

   localparam int NB = 8192;
   localparam int LD = 16;
   localparam int LA = 13;
`ifdef SRAM_BANKED_OUT_REG_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          wEn = 1'b1, rEn = 1'b1, cntClr = 1'b0;
   logic [LA-1:0] wAddr = '0, rAddr = '0;
   logic [LD-1:0] wData = '0;
   logic [LD-1:0] rData;
   logic          rValid;
   logic [31:0]   rdCnt, wrCnt;

   logic          s_wEn = 1'b1, s_rEn = 1'b1, s_cntClr = 1'b0;
   logic [5:0]    s_wAddr = '0, s_rAddr = '0;
   logic [15:0]   s_wData = '0;
   logic [15:0]   s_rData;
   logic          s_rValid;
   logic [3:0]    s_rdCnt, s_wrCnt;

   always #5 clk = ~clk;

   sram_banked_1r1w u_dut (
      .clk(clk), .rst(rst), .wEn(wEn), .wAddr(wAddr), .wData(wData),
      .rEn(rEn), .rAddr(rAddr), .rData(rData), .rValid(rValid),
      .cntClr(cntClr), .rdCnt(rdCnt), .wrCnt(wrCnt)
   );

   sram_banked_1r1w #(.NB_DATA(64), .L_DATA(16), .NB_BANK(2), .CNT_W(4)) u_sat (
      .clk(clk), .rst(rst), .wEn(s_wEn), .wAddr(s_wAddr), .wData(s_wData),
      .rEn(s_rEn), .rAddr(s_rAddr), .rData(s_rData), .rValid(s_rValid),
      .cntClr(s_cntClr), .rdCnt(s_rdCnt), .wrCnt(s_wrCnt)
   );

   typedef struct packed { logic vld; logic [LD-1:0] data; } pend_t;
   typedef struct {
      logic wen; logic [LA-1:0] wa; logic [LD-1:0] wd;
      logic ren; logic [LA-1:0] ra; logic [LD-1:0] exp;
   } vec_t;

   logic [LD-1:0] m_mem [NB];
   pend_t         pq[$];
   logic [LD-1:0] m_hold;
   int            m_rd, m_wr;
   int            n_chk = 0, n_fail = 0;
   vec_t          tbl [14];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic reset_model();
      pq.delete();
      for (int i = 0; i < LAT - 1; i++) pq.push_back('0);
      m_hold = '0;
      m_rd   = 0;
      m_wr   = 0;
   endtask

   task automatic drive(input logic we, input logic [LA-1:0] wa, input logic [LD-1:0] wd,
                        input logic re, input logic [LA-1:0] ra, input logic clr);
      wEn = we; wAddr = wa; wData = wd; rEn = re; rAddr = ra; cntClr = clr;
   endtask

   // One clock: model the request seen at the edge, then check outputs 1 time unit later.
   task automatic tick(input bit use_tbl, input logic [LD-1:0] texp);
      pend_t e, o;
      @(posedge clk);
      e.vld  = ~rEn;
      e.data = use_tbl ? texp : ((!wEn && wAddr == rAddr) ? wData : m_mem[rAddr]);
      if (!wEn) m_mem[wAddr] = wData;
      if (cntClr) begin
         m_rd = 0; m_wr = 0;
      end else begin
         if (!rEn) m_rd++;
         if (!wEn) m_wr++;
      end
      pq.push_back(e);
      o = pq.pop_front();
      if (o.vld) m_hold = o.data;
      #1;
      chk("rValid", 32'(rValid), 32'(o.vld));
      chk("rData",  32'(rData),  32'(m_hold));
      chk("rdCnt",  rdCnt, 32'(m_rd));
      chk("wrCnt",  wrCnt, 32'(m_wr));
   endtask

   initial begin
      #2_000_000;
      n_fail++;
      $display("FAIL watchdog: simulation did not finish in time");
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      logic [LA-1:0] ra;

      tbl[0]  = '{1'b0, 13'h1234, 16'h1111, 1'b1, 13'h0000, 16'h0000};
      tbl[1]  = '{1'b0, 13'h1234, 16'hBEEF, 1'b0, 13'h1234, 16'hBEEF};
      tbl[2]  = '{1'b1, 13'h0000, 16'h0000, 1'b0, 13'h1234, 16'hBEEF};
      tbl[3]  = '{1'b0, 13'h0800, 16'h00C3, 1'b1, 13'h0000, 16'h0000};
      tbl[4]  = '{1'b1, 13'h0000, 16'h0000, 1'b0, 13'h0800, 16'h00C3};
      tbl[5]  = '{1'b0, 13'h0000, 16'h0001, 1'b1, 13'h0000, 16'h0000};
      tbl[6]  = '{1'b0, 13'h1000, 16'h0002, 1'b1, 13'h0000, 16'h0000};
      tbl[7]  = '{1'b0, 13'h1800, 16'h0003, 1'b1, 13'h0000, 16'h0000};
      tbl[8]  = '{1'b0, 13'h0001, 16'h0004, 1'b1, 13'h0000, 16'h0000};
      tbl[9]  = '{1'b0, 13'h1FFF, 16'h0005, 1'b1, 13'h0000, 16'h0000};
      tbl[10] = '{1'b0, 13'h0801, 16'h7777, 1'b0, 13'h0800, 16'h00C3};
      tbl[11] = '{1'b1, 13'h0000, 16'h0000, 1'b0, 13'h0801, 16'h7777};
      tbl[12] = '{1'b1, 13'h0000, 16'h0000, 1'b0, 13'h0000, 16'h0001};
      tbl[13] = '{1'b1, 13'h0000, 16'h0000, 1'b0, 13'h1FFF, 16'h0005};

      // Reset values
      repeat (3) @(posedge clk);
      #1;
      chk("rst_rValid", 32'(rValid), 32'd0);
      chk("rst_rData",  32'(rData),  32'd0);
      chk("rst_rdCnt",  rdCnt, 32'd0);
      chk("rst_wrCnt",  wrCnt, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      reset_model();

      // Fill and read back
      for (int i = 0; i < NB; i++) begin
         drive(1'b0, 13'(i), 16'(i) ^ 16'hA5A5, 1'b1, '0, 1'b0);
         tick(1'b0, '0);
      end
      for (int i = 0; i < NB; i++) begin
         drive(1'b1, '0, '0, 1'b0, 13'(i), 1'b0);
         tick(1'b1, 16'(i) ^ 16'hA5A5);
      end
      drive(1'b1, '0, '0, 1'b1, '0, 1'b0);
      repeat (LAT) tick(1'b0, '0);
      chk("fill_wrCnt", wrCnt, 32'd8192);
      chk("fill_rdCnt", rdCnt, 32'd8192);

      // Directed: collision, hold, same-bank read+write
      for (int i = 0; i < 14; i++) begin
         drive(tbl[i].wen, tbl[i].wa, tbl[i].wd, tbl[i].ren, tbl[i].ra, 1'b0);
         tick(1'b1, tbl[i].exp);
         if (i == 9) begin
            chk("hold_rData",  32'(rData),  32'h00C3);
            chk("hold_rValid", 32'(rValid), 32'd0);
         end
      end
      drive(1'b1, '0, '0, 1'b1, '0, 1'b0);
      repeat (LAT) tick(1'b0, '0);

      // Random traffic against the model
      for (int c = 0; c < 3000; c++) begin
         ra = 13'($urandom_range(0, NB - 1));
         drive(($urandom_range(0, 2) == 0),
               ($urandom_range(0, 3) == 0) ? ra : 13'($urandom_range(0, NB - 1)),
               16'($urandom),
               ($urandom_range(0, 3) == 0),
               ra,
               ($urandom_range(0, 99) == 0));
         tick(1'b0, '0);
      end
      drive(1'b1, '0, '0, 1'b1, '0, 1'b0);
      repeat (LAT) tick(1'b0, '0);

      // Reset while a read is in flight
      drive(1'b1, '0, '0, 1'b0, 13'h0042, 1'b0);
      tick(1'b0, '0);
      rEn = 1'b1;
      #2 rst = 1'b1;
      #1;
      chk("midrst_rValid", 32'(rValid), 32'd0);
      chk("midrst_rData",  32'(rData),  32'd0);
      chk("midrst_rdCnt",  rdCnt, 32'd0);
      chk("midrst_wrCnt",  wrCnt, 32'd0);
      #1 rst = 1'b0;
      reset_model();
      repeat (LAT + 1) tick(1'b0, '0);
      drive(1'b1, '0, '0, 1'b0, 13'h0042, 1'b0);
      tick(1'b0, '0);
      drive(1'b1, '0, '0, 1'b1, '0, 1'b0);
      repeat (LAT) tick(1'b0, '0);

      // Counter saturation and clear on the narrow-counter instance
      s_rEn = 1'b0;
      for (int k = 0; k < 20; k++) begin
         @(posedge clk);
         #1;
         if (k == 14) chk("sat_rdCnt15", 32'(s_rdCnt), 32'd15);
      end
      chk("sat_rdCnt20",  32'(s_rdCnt),  32'd15);
      chk("sat_wrCnt",    32'(s_wrCnt),  32'd0);
      chk("sat_rValid",   32'(s_rValid), 32'd1);
      s_cntClr = 1'b1; s_wEn = 1'b0; s_wAddr = 6'd5; s_wData = 16'h5A5A;
      @(posedge clk);
      #1;
      chk("clr_rdCnt", 32'(s_rdCnt), 32'd0);
      chk("clr_wrCnt", 32'(s_wrCnt), 32'd0);
      s_cntClr = 1'b0; s_wEn = 1'b1; s_rAddr = 6'd5;
      @(posedge clk);
      #1;
      chk("postclr_rdCnt", 32'(s_rdCnt), 32'd1);
      s_rEn = 1'b1;
      repeat (LAT - 1) @(posedge clk);
      #1;
      chk("sat_rData",      32'(s_rData),  32'h5A5A);
      chk("sat_rValid_rd",  32'(s_rValid), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
